// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search block.
package sar_pkg;

  localparam int SAR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRY   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sar_state_e;

  // A valid comparator verdict has exactly one of gt/lt/eq asserted.
  function automatic logic onehot3_f(input logic [2:0] code);
    return (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
  endfunction

endpackage

// File: rtl/sar_code_chk.sv
// Combinational sanity check of the external comparator code {gt, lt, eq}.
module sar_code_chk
  import sar_pkg::*;
(
  input  logic gt,
  input  logic lt,
  input  logic eq,
  output logic onehot_ok
);

  assign onehot_ok = onehot3_f({gt, lt, eq});

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search FSM driving an external magnitude comparator.
// Optional SAR_EARLY_EXIT_EN: finish as soon as the comparator reports equality in TRY.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             cmp_err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_e       state_r, state_nxt_s;
  logic [WIDTH-1:0] trial_r, trial_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic             found_r, found_nxt_s;
  logic             err_r, err_nxt_s;
  logic             busy_r, done_r;
  logic             onehot_ok_s;

  sar_code_chk u_code_chk (
    .gt        (cmp_gt),
    .lt        (cmp_lt),
    .eq        (cmp_eq),
    .onehot_ok (onehot_ok_s)
  );

  // Next-state and datapath decisions for the search sequence.
  always_comb begin
    state_nxt_s  = state_r;
    trial_nxt_s  = trial_r;
    idx_nxt_s    = idx_r;
    result_nxt_s = result_r;
    found_nxt_s  = found_r;
    err_nxt_s    = err_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          trial_nxt_s = MSB_ONLY;
          idx_nxt_s   = IDX_MAX;
          found_nxt_s = 1'b0;
          err_nxt_s   = 1'b0;
          state_nxt_s = TRY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TRY: begin
        if (!onehot_ok_s) begin
          err_nxt_s    = 1'b1;
          found_nxt_s  = 1'b0;
          result_nxt_s = trial_r;
          state_nxt_s  = DONE;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (cmp_eq) begin
          found_nxt_s  = 1'b1;
          result_nxt_s = trial_r;
          state_nxt_s  = DONE;
        end
`endif
        else begin
          // Unknown below the trial means the bit under test overshoots.
          if (cmp_lt) begin
            trial_nxt_s[idx_r] = 1'b0;
          end else begin
            trial_nxt_s[idx_r] = trial_r[idx_r];
          end
          if (idx_r != {IDX_W{1'b0}}) begin
            trial_nxt_s[idx_r - IDX_W'(1)] = 1'b1;
            idx_nxt_s   = idx_r - IDX_W'(1);
            state_nxt_s = TRY;
          end else begin
            state_nxt_s = CHECK;
          end
        end
      end
      CHECK: begin
        result_nxt_s = trial_r;
        state_nxt_s  = DONE;
        if (!onehot_ok_s) begin
          err_nxt_s   = 1'b1;
          found_nxt_s = 1'b0;
        end else begin
          found_nxt_s = cmp_eq;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      trial_r  <= {WIDTH{1'b0}};
      idx_r    <= IDX_MAX;
      result_r <= {WIDTH{1'b0}};
      found_r  <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      trial_r  <= trial_nxt_s;
      idx_r    <= idx_nxt_s;
      result_r <= result_nxt_s;
      found_r  <= found_nxt_s;
      err_r    <= err_nxt_s;
      busy_r   <= (state_nxt_s == TRY) || (state_nxt_s == CHECK);
      done_r   <= (state_nxt_s == DONE);
    end
  end

  assign trial   = trial_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;
  assign found   = found_r;
  assign cmp_err = err_r;

endmodule

// File: tb/tb_sar_search.sv
// Closed-loop bench: behavioural comparator against unknown u, arithmetic reference model.
module tb_sar_search;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cmp_gt, cmp_lt, cmp_eq;
  logic [W-1:0] trial, result;
  logic         busy, done, found, cmp_err;
  logic [W-1:0] u;
  logic         force_bad;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural magnitude comparator, optionally forced to an illegal code.
  always_comb begin
    cmp_gt = force_bad ? 1'b1 : (u > trial);
    cmp_lt = force_bad ? 1'b1 : (u < trial);
    cmp_eq = force_bad ? 1'b0 : (u == trial);
  end

  sar_search #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cmp_gt  (cmp_gt),
    .cmp_lt  (cmp_lt),
    .cmp_eq  (cmp_eq),
    .trial   (trial),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .found   (found),
    .cmp_err (cmp_err)
  );

  // Step k of a binary search for uv: bits of uv above the probe position, plus the probe bit.
  function automatic logic [W-1:0] model_trial(input logic [W-1:0] uv, input int k);
    int span;
    int kept;
    span = 1 << (W - k);
    kept = (int'(uv) / span) * span;
    return W'(kept + (1 << (W - 1 - k)));
  endfunction

  function automatic int model_lat(input logic [W-1:0] uv);
`ifdef SAR_EARLY_EXIT_EN
    for (int k = 0; k < W; k++) begin
      if (model_trial(uv, k) == uv) return k + 2;
    end
`endif
    return W + 2;
  endfunction

  task automatic run_search(input logic [W-1:0] uv, input bit chk_seq, output int lat);
    u = uv;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (chk_seq && lat <= W) begin
        n_checks++;
        if (trial !== model_trial(uv, lat - 1)) begin
          n_fail++;
          $display("FAIL trial_seq u=%b step %0d: got %b expected %b", uv, lat - 1, trial, model_trial(uv, lat - 1));
        end
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout u=%b: done not seen after %0d edges", uv, lat);
    end
  endtask

  task automatic check_search(input string name, input logic [W-1:0] uv, input bit chk_seq);
    int lat;
    run_search(uv, chk_seq, lat);
    n_checks++;
    if (result !== uv) begin n_fail++; $display("FAIL %s result u=%b: got %b expected %b", name, uv, result, uv); end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL %s found u=%b: got %b expected 1", name, uv, found); end
    n_checks++;
    if (cmp_err !== 1'b0) begin n_fail++; $display("FAIL %s cmp_err u=%b: got %b expected 0", name, uv, cmp_err); end
    n_checks++;
    if (lat != model_lat(uv)) begin n_fail++; $display("FAIL %s latency u=%b: got %0d expected %0d", name, uv, lat, model_lat(uv)); end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({trial, result, busy, done, found, cmp_err} !== {(2*W+4){1'b0}}) begin
      n_fail++;
      $display("FAIL %s: trial=%b result=%b busy=%b done=%b found=%b cmp_err=%b expected all 0",
               name, trial, result, busy, done, found, cmp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; force_bad = 1'b0; u = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_known();
    check_search("known_1011", 4'b1011, 1'b1);
  endtask

  task automatic test_sweep();
    for (int v = 0; v < (1 << W); v++) check_search("sweep", W'(v), 1'b1);
  endtask

  task automatic test_msb();
    check_search("msb_only", 4'b1000, 1'b1);
  endtask

  task automatic test_random();
    repeat (8) check_search("random", W'($urandom_range((1 << W) - 1, 0)), 1'b1);
  endtask

  task automatic test_cmp_err();
    int lat;
    u = 4'b1011;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); force_bad = 1'b1;
    @(posedge clk);
    @(negedge clk);
    force_bad = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL cmp_err_done: got %b expected 1", done); end
    n_checks++;
    if (cmp_err !== 1'b1) begin n_fail++; $display("FAIL cmp_err_flag: got %b expected 1", cmp_err); end
    n_checks++;
    if (found !== 1'b0) begin n_fail++; $display("FAIL cmp_err_found: got %b expected 0", found); end
    n_checks++;
    if (result !== model_trial(4'b1011, 1)) begin n_fail++; $display("FAIL cmp_err_result: got %b expected %b", result, model_trial(4'b1011, 1)); end
    run_search(4'b0110, 1'b0, lat);
    n_checks++;
    if (cmp_err !== 1'b0 || result !== 4'b0110) begin
      n_fail++; $display("FAIL cmp_err_recover: cmp_err=%b result=%b expected 0/0110", cmp_err, result);
    end
  endtask

  task automatic test_reset_mid();
    u = 4'b1011;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_mid_search");
    rst = 1'b0; start = 1'b0;
    check_search("after_reset", 4'b0101, 1'b1);
  endtask

  task automatic test_back_to_back();
    int d;
    int dones;
    int guard;
    u = 4'b0011;
    d = model_lat(4'b0011);
    dones = 0;
    @(negedge clk); start = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (e == d + 1) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL held_start_idle edge %0d: busy got %b expected 0", e, busy); end
      end
      if (e == d + 2) begin
        n_checks++;
        if (busy !== 1'b1 || trial !== 4'b1000) begin
          n_fail++; $display("FAIL held_start_restart edge %0d: busy=%b trial=%b expected 1/1000", e, busy, trial);
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL held_start_dones: got %0d expected 1", dones); end
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    n_checks++;
    if (done !== 1'b1 || result !== 4'b0011 || found !== 1'b1) begin
      n_fail++; $display("FAIL held_start_second: done=%b result=%b found=%b expected 1/0011/1", done, result, found);
    end
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_known();
    test_msb();
    test_sweep();
    test_random();
    test_cmp_err();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter WIDTH, default 4, search width in bits; legal range 2..8.
REQ-002 clk  input  1  rising-edge clock; the block's single clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  begin a search; sampled only in IDLE.
REQ-005 cmp_gt  input  1  external comparator result: unknown > trial.
REQ-006 cmp_lt  input  1  external comparator result: unknown < trial.
REQ-007 cmp_eq  input  1  external comparator result: unknown == trial.
REQ-008 trial  output  WIDTH  registered value presented to the external comparator.
REQ-009 busy  output  1  high in TRY and CHECK.
REQ-010 done  output  1  one-cycle pulse when a search finishes.
REQ-011 result  output  WIDTH  final search value; held until the next start is accepted.
REQ-012 found  output  1  result verified equal; valid while done is high and held afterwards.
REQ-013 cmp_err  output  1  comparator code was not one-hot; valid while done is high and held afterwards.

Function
REQ-014 The block SHALL be the initiator side of a magnitude-compare interface: it drives trial and reads gt/lt/eq combinationally in the same cycle.
REQ-015 The FSM SHALL have four states: IDLE, TRY, CHECK, DONE.
REQ-016 In IDLE with start=1: trial <= MSB-only (1000 for WIDTH=4), bit index <= WIDTH-1, found <= 0, cmp_err <= 0, next state TRY.
REQ-017 In TRY, each cycle: if cmp_lt, clear trial[idx]; otherwise keep trial[idx]. If idx>0, set trial[idx-1] and decrement idx; if idx==0, go to CHECK.
REQ-018 In CHECK, the block SHALL sample cmp_eq into found, copy trial to result, and go to DONE.
REQ-019 In DONE: done=1 for exactly one cycle, then IDLE.
REQ-020 Latency without early exit SHALL be WIDTH+2 edges from the start-sampling edge to done high (6 for WIDTH=4).
REQ-021 If {cmp_gt,cmp_lt,cmp_eq} is not one-hot in TRY or CHECK: set cmp_err=1, found=0, result=trial, go directly to DONE.
REQ-022 start while busy or in DONE SHALL be ignored and not queued.
REQ-023 trial SHALL keep its last value in IDLE; trial is a don't-care to consumers outside TRY and CHECK.
REQ-024 Arithmetic is bit-set/clear only: no adder, and no wrap-around is possible.

Reset
REQ-025 rst=1 at any clock edge, including mid-search, SHALL force IDLE with trial=0, result=0, busy=0, done=0, found=0, cmp_err=0, idx=WIDTH-1.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro SAR_EARLY_EXIT_EN, when defined: cmp_eq=1 (one-hot) in TRY SHALL set found=1, set result=trial, and go straight to DONE. Minimum latency is then 2 edges: trial = MSB value, one TRY cycle, then DONE.
REQ-028 Without SAR_EARLY_EXIT_EN: eq in TRY is treated as not-lt (bit kept), and every search takes exactly WIDTH+2 edges.

Structure
REQ-029 Package sar_pkg SHALL hold the state enum (IDLE/TRY/CHECK/DONE) and the default WIDTH constant.
REQ-030 One sub-module, sar_code_chk, SHALL be combinational: it takes gt/lt/eq and outputs onehot_ok.
REQ-031 The FSM, trial register and index counter SHALL reside in sar_search.

Verification
REQ-032 The bench closes the loop with a behavioural magnitude comparator against unknown U. U=4'b1011, start pulse -> trial sequence 1000,1100,1010,1011; done on edge 6; result=1011; found=1; cmp_err=0.
REQ-033 Exhaustive sweep U=0..15 -> result==U, found=1 for every U; latency 6 without the macro.
REQ-034 With SAR_EARLY_EXIT_EN, U=8 -> done on edge 2 with result=1000, found=1. Without the macro, U=8 -> done on edge 6, result=1000.
REQ-035 Force gt=lt=1 on the second TRY cycle -> done the next cycle, cmp_err=1, found=0.
REQ-036 Assert rst on the third TRY cycle, then start again with U=5 -> all outputs 0 after the reset edge; second search returns 0101.
REQ-037 start held high for 10 cycles with U=3 -> exactly one search (single done pulse) during busy; a second search begins only on the first IDLE cycle.
